// File: rtl/fp_convert_seq_if.sv
// Handshake bundle for fp_convert_seq.
//
// Purpose: carries the sample input channel and the converted result channel
// between the sample source, the converter and the display/encode stage.
//
// Valid/ready semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. Once valid is raised, the producer
// holds valid and its payload steady until that edge. Ready may change at any
// time, and it has no effect while valid is low.
//
// Signals:
//   in_valid / in_ready / in_data            input channel (source -> converter)
//   out_valid / out_ready                    result channel (converter -> sink)
//   S, E, F, norm_shift, sat                 result payload
// Modports:
//   master : the side that drives samples and accepts results (bench/system)
//   slave  : the converter
interface fp_convert_seq_if #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
);
  localparam int SH_W = $clog2(IN_W - MAN_W + 1);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             S;
  logic [EXP_W-1:0] E;
  logic [MAN_W-1:0] F;
  logic [SH_W-1:0]  norm_shift;
  logic             sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, S, E, F, norm_shift, sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, S, E, F, norm_shift, sat
  );
endinterface

// File: rtl/fp_convert_seq.sv
// Sequential two's-complement to compact floating-point converter.
//
// Purpose: turns an IN_W-bit signed sample into sign S, exponent E and
// mantissa F (value ~ F * 2^E). Normalisation shifts left one bit per cycle.
// Round-to-nearest uses the first bit below the mantissa; a rounding carry
// bumps the exponent; an exponent beyond MAX_E saturates the result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        fp_convert_seq_if.slave (input channel, result channel, payload)
//   state_dbg  current FSM state (debug visibility)
module fp_convert_seq #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  fp_convert_seq_if.slave   bus,
  output logic [2:0]        state_dbg
);

  localparam int SH_W     = $clog2(IN_W - MAN_W + 1);
  localparam int NORM_MAX = IN_W - MAN_W;
  localparam int MAX_E    = (1 << EXP_W) - 1;
  // Working exponent must hold NORM_MAX+1 (rounding carry) and MAX_E+1
  // so the saturation compare cannot wrap.
  localparam int EW_RAW   = $clog2(NORM_MAX + 2);
  localparam int EW       = (EW_RAW > EXP_W) ? EW_RAW : EXP_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    NORM  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state;
  logic [IN_W-1:0]   data_q;
  logic              sgn;
  logic [IN_W-1:0]   mag;
  logic [EW-1:0]     e;
  logic [SH_W-1:0]   k;

  logic [MAN_W:0]    fr_sum;
  logic [MAN_W-1:0]  f_fin;
  logic [EW-1:0]     e_fin;
  logic              sat_now;

  assign state_dbg    = state;
  assign bus.in_ready = (state == IDLE);

  // Rounding of the normalised magnitude, consumed in ROUND.
  always_comb begin
    fr_sum  = {1'b0, mag[IN_W-1 -: MAN_W]} + {{MAN_W{1'b0}}, mag[IN_W-MAN_W-1]};
    f_fin   = fr_sum[MAN_W-1:0];
    e_fin   = e;
    if (fr_sum[MAN_W]) begin
      // Mantissa overflowed: 1.111 + 1 becomes 10.00, renormalise by one.
      f_fin = {1'b1, {(MAN_W-1){1'b0}}};
      e_fin = e + 1'b1;
    end
    sat_now = (e_fin > EW'(MAX_E));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      data_q         <= '0;
      sgn            <= 1'b0;
      mag            <= '0;
      e              <= '0;
      k              <= '0;
      bus.out_valid  <= 1'b0;
      bus.S          <= 1'b0;
      bus.E          <= '0;
      bus.F          <= '0;
      bus.norm_shift <= '0;
      bus.sat        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q <= bus.in_data;
            state  <= LOAD;
          end
        end
        LOAD: begin
          sgn   <= data_q[IN_W-1];
          // The most negative input yields a magnitude with only the MSB set.
          mag   <= data_q[IN_W-1] ? (~data_q + 1'b1) : data_q;
          e     <= EW'(NORM_MAX);
          k     <= '0;
          state <= NORM;
        end
        NORM: begin
          if (!mag[IN_W-1] && (e != '0)) begin
            mag <= {mag[IN_W-2:0], 1'b0};
            e   <= e - 1'b1;
            k   <= k + 1'b1;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          bus.S          <= sgn;
          bus.norm_shift <= k;
          if (sat_now) begin
            bus.E   <= EXP_W'(MAX_E);
            bus.F   <= '1;
            bus.sat <= 1'b1;
          end else begin
            bus.E   <= e_fin[EXP_W-1:0];
            bus.F   <= f_fin;
            bus.sat <= 1'b0;
          end
          state <= DONE;
        end
        DONE: begin
          // Result registers settle on entry; valid follows one cycle later.
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= IDLE;
          end else begin
            bus.out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_convert_seq.sv
module tb_fp_convert_seq;

  localparam int IN_W  = 12;
  localparam int EXP_W = 3;
  localparam int MAN_W = 4;
  localparam int SH_W  = $clog2(IN_W - MAN_W + 1);
  localparam int RW    = 1 + EXP_W + MAN_W + SH_W + 1;

  logic       clk;
  logic       rst;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] exp_q[$];
  int            lat_q[$];

  fp_convert_seq_if #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) ifc ();

  fp_convert_seq #(.IN_W(IN_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (ifc.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Value-level conversion: find the bit length of |x|, shift left as far as
  // allowed, round on the next bit, then saturate on exponent overflow.
  function automatic logic [RW-1:0] model(input logic [IN_W-1:0] d, output int lat);
    int sv, mag, len, k, m, fr, rb, sum, ex;
    logic s, sat;
    logic [EXP_W-1:0] eo;
    logic [MAN_W-1:0] fo;
    sv  = (int'(d) >= (1 << (IN_W-1))) ? int'(d) - (1 << IN_W) : int'(d);
    s   = (sv < 0);
    mag = s ? -sv : sv;
    len = 0;
    while ((1 << len) <= mag) len++;
    k   = IN_W - len;
    if (k > IN_W - MAN_W) k = IN_W - MAN_W;
    m   = mag * (1 << k);
    fr  = m / (1 << (IN_W - MAN_W));
    rb  = (m / (1 << (IN_W - MAN_W - 1))) % 2;
    sum = fr + rb;
    ex  = IN_W - MAN_W - k;
    if (sum == (1 << MAN_W)) begin
      sum = 1 << (MAN_W - 1);
      ex  = ex + 1;
    end
    if (ex > (1 << EXP_W) - 1) begin
      sat = 1'b1;
      eo  = '1;
      fo  = '1;
    end else begin
      sat = 1'b0;
      eo  = EXP_W'(ex);
      fo  = MAN_W'(sum);
    end
    lat = k + 4;
    return {s, eo, fo, SH_W'(k), sat};
  endfunction

  function automatic logic [RW-1:0] observed();
    return {ifc.S, ifc.E, ifc.F, ifc.norm_shift, ifc.sat};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic convert(input logic [IN_W-1:0] d, input int stall);
    int lat_exp, cyc;
    logic [RW-1:0] held;
    exp_q.push_back(model(d, lat_exp));
    lat_q.push_back(lat_exp);
    check("in_ready_idle", 32'(ifc.in_ready), 32'd1);
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.in_data  = IN_W'($urandom);
    cyc = 0;
    while (!ifc.out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(lat_q.pop_front()));
    held = observed();
    check("result", 32'(held), 32'(exp_q.pop_front()));
    for (int i = 0; i < stall; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = IN_W'($urandom);
      @(posedge clk); #1;
      check("stall_valid", 32'(ifc.out_valid), 32'd1);
      check("stall_in_ready", 32'(ifc.in_ready), 32'd0);
      check("stall_stable", 32'(observed()), 32'(held));
    end
    ifc.out_ready = 1'b1;
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b0;
    check("post_valid", 32'(ifc.out_valid), 32'd0);
    check("post_in_ready", 32'(ifc.in_ready), 32'd1);
    check("post_hold", 32'(observed()), 32'(held));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int ghost;
    rst           = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b0;
    @(posedge clk); #1;
    reset_dut();
    check("reset_out_valid", 32'(ifc.out_valid), 32'd0);
    check("reset_in_ready", 32'(ifc.in_ready), 32'd1);
    check("reset_outputs", 32'(observed()), 32'd0);

    convert(12'd422, 1);
    convert(12'd46, 0);
    convert(12'd63, 2);
    convert(12'h800, 0);
    convert(12'h801, 1);
    convert(12'd2047, 0);
    convert(12'd0, 0);
    convert(12'hFFF, 1);
    // Long backpressure with junk offered on the input channel.
    convert(12'd1234, 5);

    // Reset while normalising a small value (deep NORM).
    ifc.in_valid = 1'b1;
    ifc.in_data  = 12'd1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_norm_in_ready", 32'(ifc.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
    check("midrst_outputs", 32'(observed()), 32'd0);
    ghost = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ifc.out_valid) ghost++;
    end
    check("midrst_no_ghost", 32'(ghost), 32'd0);
    convert(12'd422, 0);

    for (int i = 0; i < 24; i++) begin
      convert(IN_W'($urandom_range(0, (1 << IN_W) - 1)), $urandom_range(0, 3));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
